// File: rtl/piso_frame_arbiter_if.sv
// Requester handshake and PISO drive bundle for piso_frame_arbiter.
interface piso_frame_arbiter_if #(
  parameter int NUM_REQ = 4
);
  localparam int IW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   req_valid;
  logic [8*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 piso_load;
  logic [7:0]           piso_data;
  logic                 busy;
  logic [IW-1:0]        grant_id;
  logic                 frame_done;
  logic                 init_done;

  modport master (
    output req_valid, req_data,
    input  req_ready, piso_load, piso_data, busy, grant_id, frame_done, init_done
  );

  modport slave (
    input  req_valid, req_data,
    output req_ready, piso_load, piso_data, busy, grant_id, frame_done, init_done
  );
endinterface

// File: rtl/piso_frame_arbiter.sv
// Round-robin arbiter feeding a shared PISO with back-to-back serial frames:
// start bit, 8 data bits LSB-first, 1+GAP stop/idle bits.
module piso_frame_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int GAP     = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  piso_frame_arbiter_if.slave  bus
);
  localparam int          IW   = $clog2(NUM_REQ);
  localparam int          CW   = 5;
  localparam int unsigned N    = NUM_REQ;
  localparam logic [CW-1:0] LAST = CW'(9 + GAP);

  localparam logic [1:0] FLUSH = 2'd0;
  localparam logic [1:0] IDLE  = 2'd1;
  localparam logic [1:0] SHIFT = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] grant_q;
  logic          init_q;
  logic          found;
  logic          grant_pt;
  logic          grant;

  // Round-robin search from ptr upward with wrap; first valid requester wins.
  always_comb begin
    int unsigned idx;
    logic [IW-1:0] cand;
    winner = ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = i + 32'(ptr);
      if (idx >= N) idx = idx - N;
      cand = IW'(idx);
      if (!found && bus.req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grants are gated by rst_n so nothing is accepted during a reset cycle.
  assign grant_pt = rst_n && ((state == IDLE) || (state == SHIFT && cnt == LAST));
  assign grant    = grant_pt && found;

  always_comb begin
    bus.piso_load = grant;
    bus.piso_data = '0;
    bus.req_ready = '0;
    if (grant) begin
      bus.piso_data = bus.req_data[8*winner +: 8];
      bus.req_ready = NUM_REQ'(1) << winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= FLUSH;
      cnt     <= '0;
      ptr     <= '0;
      grant_q <= '0;
      init_q  <= 1'b0;
    end else begin
      case (state)
        FLUSH: begin
          if (cnt == CW'(8)) begin
            state  <= IDLE;
            cnt    <= '0;
            init_q <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        IDLE, SHIFT: begin
          if (grant) begin
            state   <= SHIFT;
            cnt     <= '0;
            grant_q <= winner;
            ptr     <= (winner == IW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
          end else if (grant_pt) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= FLUSH;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.busy       = (state == SHIFT);
  assign bus.frame_done = (state == SHIFT) && (cnt == CW'(9));
  assign bus.init_done  = init_q;
  assign bus.grant_id   = grant_q;
endmodule
